// File: rtl/imem_load_arb.sv
// imem_load_arb
//   Arbitrates the single-port instruction memory between a byte-serial
//   program loader and the pipeline fetch stage. While loading, bytes are
//   packed little-endian into 32-bit words and written one word per WRITE
//   cycle. Once the image is complete, the memory serves fetches with
//   one-cycle latency.
//
// Ports
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   ld_start, ld_base   begin/restart a load at word index ld_base
//   ld_valid, ld_byte   loader byte stream; ld_ready = byte accepted
//   ld_done             end-of-image pulse
//   boot_done           image resident, fetch enabled
//   fetch_req/addr      pipeline fetch request (byte address)
//   fetch_rdata/valid   registered instruction word, one cycle later
//   fetch_stall         pipeline must hold its PC
//   mem_addr/wdata/we   memory word index, write data, write enable
//   mem_rdata           combinational memory read data
module imem_load_arb #(
  parameter int unsigned AddrSize = 16,
  parameter int unsigned WordSize = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ld_start,
  input  logic [AddrSize-1:0] ld_base,
  input  logic                ld_valid,
  input  logic [7:0]          ld_byte,
  output logic                ld_ready,
  input  logic                ld_done,
  output logic                boot_done,
  input  logic                fetch_req,
  input  logic [31:0]         fetch_addr,
  output logic [WordSize-1:0] fetch_rdata,
  output logic                fetch_valid,
  output logic                fetch_stall,
  output logic [AddrSize-1:0] mem_addr,
  output logic [WordSize-1:0] mem_wdata,
  output logic                mem_we,
  input  logic [WordSize-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_LOAD,
    S_WRITE,
    S_RUN
  } state_e;

  state_e                state_q, state_d;
  logic [AddrSize-1:0]   ptr_q, ptr_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [WordSize-1:0]   shift_q, shift_d;
  logic                  final_q, final_d;
  logic [WordSize-1:0]   rdata_q, rdata_d;
  logic                  fvalid_q, fvalid_d;

  // Byte-offset and out-of-range fetch address bits are intentionally ignored.
  logic unused_fetch_bits;
  assign unused_fetch_bits = ^{fetch_addr[31:AddrSize+2], fetch_addr[1:0]};

  assign fetch_rdata = rdata_q;
  assign fetch_valid = fvalid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_BOOT;
      ptr_q    <= '0;
      cnt_q    <= '0;
      shift_q  <= '0;
      final_q  <= 1'b0;
      rdata_q  <= '0;
      fvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      final_q  <= final_d;
      rdata_q  <= rdata_d;
      fvalid_q <= fvalid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    final_d     = final_q;
    rdata_d     = rdata_q;
    fvalid_d    = 1'b0;
    ld_ready    = 1'b0;
    boot_done   = 1'b0;
    fetch_stall = 1'b1;
    mem_we      = 1'b0;
    mem_addr    = ptr_q;
    mem_wdata   = '0;

    unique case (state_q)
      S_BOOT: begin
        if (ld_start) begin
          ptr_d   = ld_base;
          cnt_d   = '0;
          shift_d = '0;
          final_d = 1'b0;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        ld_ready = 1'b1;
        if (ld_start) begin
          // Restart discards any partially packed word.
          ptr_d   = ld_base;
          cnt_d   = '0;
          shift_d = '0;
          final_d = 1'b0;
        end else begin
          if (ld_valid) begin
            shift_d[{cnt_q, 3'b000} +: 8] = ld_byte;
            cnt_d = cnt_q + 2'd1;
          end
          // A byte arriving with ld_done is packed first; the word is then
          // flushed as the final one.
          if (ld_valid && cnt_q == 2'd3) begin
            state_d = S_WRITE;
            final_d = ld_done;
          end else if (ld_done) begin
            if (ld_valid || cnt_q != 2'd0) begin
              state_d = S_WRITE;
              final_d = 1'b1;
            end else begin
              state_d = S_RUN;
            end
          end
        end
      end

      S_WRITE: begin
        mem_we    = 1'b1;
        mem_wdata = shift_q;
        if (ld_start) begin
          ptr_d   = ld_base;
          cnt_d   = '0;
          shift_d = '0;
          final_d = 1'b0;
          state_d = S_LOAD;
        end else begin
          ptr_d   = ptr_q + 1'b1;
          cnt_d   = '0;
          shift_d = '0;
          final_d = 1'b0;
          state_d = final_q ? S_RUN : S_LOAD;
        end
      end

      S_RUN: begin
        mem_addr = fetch_addr[AddrSize+1:2];
        if (ld_start) begin
          // Stall and drop the fetch in the very cycle the reload begins.
          ptr_d   = ld_base;
          cnt_d   = '0;
          shift_d = '0;
          final_d = 1'b0;
          state_d = S_LOAD;
        end else begin
          boot_done   = 1'b1;
          fetch_stall = 1'b0;
          if (fetch_req) begin
            fvalid_d = 1'b1;
            rdata_d  = mem_rdata;
          end
        end
      end

      default: state_d = S_BOOT;
    endcase
  end

endmodule

// File: tb/tb_imem_load_arb.sv
module tb_imem_load_arb;

  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ld_start = 1'b0;
  logic [AW-1:0] ld_base = '0;
  logic          ld_valid = 1'b0;
  logic [7:0]    ld_byte = '0;
  logic          ld_ready;
  logic          ld_done = 1'b0;
  logic          boot_done;
  logic          fetch_req = 1'b0;
  logic [31:0]   fetch_addr = '0;
  logic [31:0]   fetch_rdata;
  logic          fetch_valid;
  logic          fetch_stall;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic [31:0]   mem_rdata;

  imem_load_arb #(.AddrSize(AW), .WordSize(32)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ld_start   (ld_start),
    .ld_base    (ld_base),
    .ld_valid   (ld_valid),
    .ld_byte    (ld_byte),
    .ld_ready   (ld_ready),
    .ld_done    (ld_done),
    .boot_done  (boot_done),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_rdata(fetch_rdata),
    .fetch_valid(fetch_valid),
    .fetch_stall(fetch_stall),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory with combinational read.
  logic [31:0] mem [0:(1<<AW)-1];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] = mem_wdata;
  end

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t         wq[$];
  logic [31:0] fq[$];
  logic [7:0]  img[$];
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: pop expected writes / fetch responses as they appear.
  always @(negedge clk) begin
    if (reset_n && mem_we) begin
      wr_t e;
      chk("write_pending", 32'(wq.size() != 0), 32'd1);
      chk("ld_ready_in_write", 32'(ld_ready), 32'd0);
      if (wq.size() != 0) begin
        e = wq.pop_front();
        chk("write_addr", 32'(mem_addr), 32'(e.a));
        chk("write_data", mem_wdata, e.d);
      end
    end
    if (reset_n && fetch_valid) begin
      chk("fetch_pending", 32'(fq.size() != 0), 32'd1);
      if (fq.size() != 0) chk("fetch_rdata", fetch_rdata, fq.pop_front());
    end
  end

  task automatic wait_ready(input string tag);
    bit ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (ld_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit with_done);
    wait_ready("byte_ready");
    ld_valid = 1'b1;
    ld_byte  = b;
    ld_done  = with_done;
    tick();
    ld_valid = 1'b0;
    ld_done  = 1'b0;
  endtask

  task automatic pulse_start(input logic [AW-1:0] base);
    ld_start = 1'b1;
    ld_base  = base;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic pulse_done();
    wait_ready("done_ready");
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
  endtask

  task automatic wait_boot();
    for (int c = 0; c < 50; c++) begin
      if (boot_done) break;
      tick();
    end
    chk("boot_done", 32'(boot_done), 32'd1);
    chk("fetch_stall_run", 32'(fetch_stall), 32'd0);
    chk("writes_drained_at_boot", 32'(wq.size()), 32'd0);
  endtask

  // Loads img[] at base; expected words are packed little-endian with zero pad.
  task automatic run_load(input logic [AW-1:0] base, input bit merge_done);
    int unsigned n = img.size();
    for (int unsigned i = 0; i < n; i += 4) begin
      wr_t e;
      e.d = '0;
      for (int unsigned k = 0; k < 4; k++)
        if (i + k < n) e.d[8*k +: 8] = img[i+k];
      e.a = base + AW'(i / 4);
      wq.push_back(e);
    end
    pulse_start(base);
    for (int unsigned i = 0; i < n; i++) send_byte(img[i], merge_done && (i == n - 1));
    if (!merge_done) pulse_done();
    wait_boot();
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp);
    fq.push_back(exp);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    tick();
    fetch_req  = 1'b0;
  endtask

  initial begin
    for (int unsigned i = 0; i < (1 << AW); i++) mem[i] = 32'hDEAD0000 | i;

    // Reset values
    #2;
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_boot_done", 32'(boot_done), 32'd0);
    chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    chk("rst_fetch_rdata", fetch_rdata, 32'd0);
    chk("rst_fetch_stall", 32'(fetch_stall), 32'd1);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    // Basic two-word image at 0
    img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(16'h0000, 1'b0);
    fetch(32'h4, 32'h00100093);
    fetch(32'h0, 32'h00000013);
    fetch(32'h4, 32'h00100093);
    fetch(32'h0004_0004, 32'h00100093);
    tick();
    tick();

    // Partial last word, zero padded
    img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    run_load(16'h0020, 1'b0);
    fetch(32'h80, 32'hDDCCBBAA);
    fetch(32'h84, 32'h000000EE);
    tick();
    tick();

    // Word pointer wraps past the top of the memory
    img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    run_load(16'hFFFF, 1'b0);
    fetch(32'h0003_FFFC, 32'h04030201);
    fetch(32'h0, 32'h08070605);
    tick();
    tick();

    // ld_start in RUN with a fetch in the same cycle
    fetch_req  = 1'b1;
    fetch_addr = 32'h0;
    ld_start   = 1'b1;
    ld_base    = 16'h0010;
    #1;
    chk("restart_stall_same_cycle", 32'(fetch_stall), 32'd1);
    chk("restart_boot_done_same_cycle", 32'(boot_done), 32'd0);
    @(posedge clk);
    #1;
    ld_start  = 1'b0;
    fetch_req = 1'b0;
    chk("restart_no_fetch_valid", 32'(fetch_valid), 32'd0);
    chk("restart_ld_ready", 32'(ld_ready), 32'd1);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    // Restart after two bytes; the last byte arrives together with ld_done.
    img = '{8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    run_load(16'h0010, 1'b1);
    fetch(32'h40, 32'h66554433);
    fetch(32'h44, 32'h00000077);
    tick();
    tick();

    // Reset asserted during WRITE
    pulse_start(16'h0030);
    send_byte(8'hC1, 1'b0);
    send_byte(8'hC2, 1'b0);
    send_byte(8'hC3, 1'b0);
    send_byte(8'hC4, 1'b0);
    chk("write_before_reset", 32'(mem_we), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("reset_mem_we", 32'(mem_we), 32'd0);
    chk("reset_fetch_stall", 32'(fetch_stall), 32'd1);
    chk("reset_boot_done", 32'(boot_done), 32'd0);
    chk("reset_ld_ready", 32'(ld_ready), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    // ld_done in BOOT is ignored
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    tick();
    chk("boot_ignores_done_ready", 32'(ld_ready), 32'd0);
    chk("boot_ignores_done_boot", 32'(boot_done), 32'd0);
    chk("boot_ignores_done_stall", 32'(fetch_stall), 32'd1);

    img = '{8'h9A, 8'h9B, 8'h9C, 8'h9D};
    run_load(16'h0005, 1'b0);
    fetch(32'h14, 32'h9D9C9B9A);
    tick();
    tick();

    chk("writes_drained", 32'(wq.size()), 32'd0);
    chk("fetches_drained", 32'(fq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
